// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Groups the execute-to-memory bundle, the M-stage forwarding source and the
// memory-to-writeback bundle of the memory stage.
//   master : upstream/harness side, drives the e_* bundle and observes
//            the forwarding source and the w_* bundle.
//   slave  : the memory stage itself.
// Signals:
//   e_pc, e_instr, e_ao, e_rt, e_tar_reg, e_wd, e_grf_we, e_tnew,
//   e_is_lw, e_is_sw                  instruction leaving execute
//   m_fwd_reg, m_fwd_val, m_tnew      forwarding source held in M
//   w_pc, w_instr, w_tar_reg, w_wd,
//   w_grf_we, w_tnew                  bundle into the M/W register
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ao;
    logic [31:0] e_rt;
    logic [4:0]  e_tar_reg;
    logic [31:0] e_wd;
    logic        e_grf_we;
    logic [3:0]  e_tnew;
    logic        e_is_lw;
    logic        e_is_sw;

    logic [4:0]  m_fwd_reg;
    logic [31:0] m_fwd_val;
    logic [3:0]  m_tnew;

    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [4:0]  w_tar_reg;
    logic [31:0] w_wd;
    logic        w_grf_we;
    logic [3:0]  w_tnew;

    modport master (
        output e_pc, e_instr, e_ao, e_rt, e_tar_reg, e_wd, e_grf_we, e_tnew,
               e_is_lw, e_is_sw,
        input  m_fwd_reg, m_fwd_val, m_tnew,
               w_pc, w_instr, w_tar_reg, w_wd, w_grf_we, w_tnew
    );

    modport slave (
        input  e_pc, e_instr, e_ao, e_rt, e_tar_reg, e_wd, e_grf_we, e_tnew,
               e_is_lw, e_is_sw,
        output m_fwd_reg, m_fwd_val, m_tnew,
               w_pc, w_instr, w_tar_reg, w_wd, w_grf_we, w_tnew
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage pipeline. Holds the E/M pipeline register and
// the word-addressed data memory, executes lw/sw and produces the bundle for
// the M/W register plus the M-stage forwarding source for the hazard unit.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears pipeline registers and DM
//   bus    mem_stage_if.slave (e_* in; m_fwd_*, m_tnew, w_* out)
// Optional feature: define DM_TRACE_EN to print one line per DM write.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int          DM_DEPTH = 1024,
    parameter int          DM_AW    = 10,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    // Saturating decrement used for the tnew hand-off into writeback.
    function automatic logic [3:0] tnew_dec(input logic [3:0] t);
        logic [3:0] r;
        if (t == 4'd0) begin
            r = 4'd0;
        end else begin
            r = t - 4'd1;
        end
        return r;
    endfunction

    // E/M pipeline registers
    logic [31:0] m_pc_r;
    logic [31:0] m_instr_r;
    logic [31:0] m_ao_r;
    logic [31:0] m_rt_r;
    logic [4:0]  m_tar_reg_r;
    logic [31:0] m_wd_r;
    logic        m_grf_we_r;
    logic [3:0]  m_tnew_r;
    logic        m_is_lw_r;
    logic        m_is_sw_r;

    // M/W pipeline registers
    logic [31:0] w_pc_r;
    logic [31:0] w_instr_r;
    logic [4:0]  w_tar_reg_r;
    logic [31:0] w_wd_r;
    logic        w_grf_we_r;
    logic [3:0]  w_tnew_r;

    // Data memory and its combinational read path
    logic [31:0]      dm_r [DM_DEPTH];
    logic [DM_AW-1:0] dm_idx_s;
    logic [31:0]      rdata_s;

    logic [4:0]  fwd_reg_s;
    logic [31:0] fwd_val_s;

    // Byte-offset and high address bits take no part in word indexing;
    // higher bits wrap modulo DM_DEPTH.
    logic unused_ao_s;
    assign unused_ao_s = ^{m_ao_r[31:DM_AW+2], m_ao_r[1:0]};

    assign dm_idx_s = m_ao_r[DM_AW+1:2];
    assign rdata_s  = dm_r[dm_idx_s];

    // E/M register: captures the execute bundle every cycle (no stall/flush).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc_r      <= PC_RESET;
            m_instr_r   <= 32'd0;
            m_ao_r      <= 32'd0;
            m_rt_r      <= 32'd0;
            m_tar_reg_r <= 5'd0;
            m_wd_r      <= 32'd0;
            m_grf_we_r  <= 1'b0;
            m_tnew_r    <= 4'd0;
            m_is_lw_r   <= 1'b0;
            m_is_sw_r   <= 1'b0;
        end else begin
            m_pc_r      <= bus.e_pc;
            m_instr_r   <= bus.e_instr;
            m_ao_r      <= bus.e_ao;
            m_rt_r      <= bus.e_rt;
            m_tar_reg_r <= bus.e_tar_reg;
            m_wd_r      <= bus.e_wd;
            m_grf_we_r  <= bus.e_grf_we;
            m_tnew_r    <= bus.e_tnew;
            m_is_lw_r   <= bus.e_is_lw;
            m_is_sw_r   <= bus.e_is_sw;
        end
    end

    // Data memory write port; reset wins over a coinciding store edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                dm_r[i] <= 32'd0;
            end
        end else if (m_is_sw_r) begin
            dm_r[dm_idx_s] <= m_rt_r;
`ifdef DM_TRACE_EN
            $display("%d@%h: *%h <= %h", $time, m_pc_r, {m_ao_r[31:2], 2'b00}, m_rt_r);
`endif
        end
    end

    // M/W register: load data replaces m_wd for lw; lw always writes back.
    // When lw and sw collide, rdata is the pre-store value since the
    // write lands at the same edge that captures it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_pc_r      <= PC_RESET;
            w_instr_r   <= 32'd0;
            w_tar_reg_r <= 5'd0;
            w_wd_r      <= 32'd0;
            w_grf_we_r  <= 1'b0;
            w_tnew_r    <= 4'd0;
        end else begin
            w_pc_r      <= m_pc_r;
            w_instr_r   <= m_instr_r;
            w_tar_reg_r <= m_tar_reg_r;
            w_wd_r      <= m_is_lw_r ? rdata_s : m_wd_r;
            w_grf_we_r  <= m_grf_we_r | m_is_lw_r;
            w_tnew_r    <= tnew_dec(m_tnew_r);
        end
    end

    // Forwarding source: only a finished, non-load result may leave M.
    always_comb begin
        fwd_reg_s = 5'd0;
        fwd_val_s = 32'd0;
        if (m_grf_we_r && (m_tnew_r == 4'd0) && !m_is_lw_r) begin
            fwd_reg_s = m_tar_reg_r;
            fwd_val_s = m_wd_r;
        end else begin
            fwd_reg_s = 5'd0;
            fwd_val_s = 32'd0;
        end
    end

    assign bus.m_fwd_reg = fwd_reg_s;
    assign bus.m_fwd_val = fwd_val_s;
    assign bus.m_tnew    = m_tnew_r;
    assign bus.w_pc      = w_pc_r;
    assign bus.w_instr   = w_instr_r;
    assign bus.w_tar_reg = w_tar_reg_r;
    assign bus.w_wd      = w_wd_r;
    assign bus.w_grf_we  = w_grf_we_r;
    assign bus.w_tnew    = w_tnew_r;

endmodule
